// File: rtl/ppi_pkg.sv
// Shared types and helpers for the filt_ppi polyphase interpolator blocks.
package ppi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } ppi_state_t;

  // $clog2 with a floor of 1 so that single-value selectors still get a bit.
  function automatic int ppi_clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ppi_fill_counter.sv
// Saturating fill counter with a terminal flag; shared by interpolator and decimator controllers.
module ppi_fill_counter #(
  parameter int gp_max   = 4,
  parameter int gp_width = $clog2(gp_max + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ena,
  output logic [gp_width-1:0] o_count,
  output logic                o_full
);

  localparam logic [gp_width-1:0] c_max = gp_width'(gp_max);

  logic [gp_width-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_ena && (count != c_max)) begin
      count <= count + gp_width'(1);
    end
  end

  assign o_count = count;
  assign o_full  = (count == c_max);

endmodule

// File: rtl/ppi_commutator_ctrl.sv
// Commutator sequencer for the polyphase interpolator: one input sample, L phase MACs, L outputs.
// Define PPI_CTRL_PRIME_GATE_EN to skip the phase sweep for warm-up samples.
module ppi_commutator_ctrl
  import ppi_pkg::*;
#(
  parameter int  gp_interp_factor = 4,
  parameter int  gp_nr_stages     = 4,
  localparam int c_phase_width    = ppi_clog2_min1(gp_interp_factor),
  localparam int c_fill_width     = $clog2(gp_nr_stages + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  output logic                     o_sr_ena,
  output logic [c_phase_width-1:0] o_phase,
  output logic                     o_mac_start,
  input  logic                     i_mac_done,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_primed,
  output logic                     o_busy
);

  localparam logic [c_phase_width-1:0] c_last_phase = c_phase_width'(gp_interp_factor - 1);

  ppi_state_t               state;
  ppi_state_t               state_nxt;
  logic [c_phase_width-1:0] phase;
  logic [c_phase_width-1:0] phase_nxt;
  logic [c_fill_width-1:0]  fill_cnt;
  logic                     fill_full;
  logic                     warmup_skip;

  ppi_fill_counter #(
    .gp_max   (gp_nr_stages),
    .gp_width (c_fill_width)
  ) u_fill (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ena   (o_sr_ena),
    .o_count (fill_cnt),
    .o_full  (fill_full)
  );

`ifdef PPI_CTRL_PRIME_GATE_EN
  // Pre-increment count: the sample that completes the fill still sweeps all phases.
  assign warmup_skip = (fill_cnt < c_fill_width'(gp_nr_stages - 1));
`else
  logic unused_fill;
  assign unused_fill = ^fill_cnt;
  assign warmup_skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      S_IDLE: begin
        if (i_data_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        phase_nxt = '0;
        state_nxt = warmup_skip ? S_IDLE : S_START;
      end
      S_START: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_mac_done) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_out_ready) begin
          if (phase == c_last_phase) begin
            phase_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            phase_nxt = phase + c_phase_width'(1);
            state_nxt = S_START;
          end
        end
      end
      default: begin
        phase_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      phase        <= '0;
      o_data_ready <= 1'b1;
      o_busy       <= 1'b0;
      o_sr_ena     <= 1'b0;
      o_mac_start  <= 1'b0;
      o_out_valid  <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      o_data_ready <= (state_nxt == S_IDLE);
      o_busy       <= (state_nxt != S_IDLE);
      o_sr_ena     <= (state_nxt == S_SHIFT);
      o_mac_start  <= (state_nxt == S_START);
      o_out_valid  <= (state_nxt == S_OUT);
    end
  end

  assign o_phase  = phase;
  assign o_primed = fill_full;

endmodule

// File: tb/tb_ppi_commutator_ctrl.sv
// Directed bench for ppi_commutator_ctrl with a step-script reference model checked every cycle.
module tb_ppi_commutator_ctrl;

  localparam int L  = 4;
  localparam int N  = 4;
  localparam int PW = 2;

`ifdef PPI_CTRL_PRIME_GATE_EN
  localparam int EXP_OV_FILL = L;
`else
  localparam int EXP_OV_FILL = N * L;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          auto_mac = 1'b1;
  logic          man_done = 1'b0;
  logic          auto_done = 1'b0;
  logic          start_neg = 1'b0;
  logic          mac_done;
  logic          o_data_ready, o_sr_ena, o_mac_start, o_out_valid, o_primed, o_busy;
  logic [PW-1:0] o_phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mac_done = auto_mac ? auto_done : man_done;

  ppi_commutator_ctrl #(
    .gp_interp_factor (L),
    .gp_nr_stages     (N)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_valid (data_valid),
    .o_data_ready (o_data_ready),
    .o_sr_ena     (o_sr_ena),
    .o_phase      (o_phase),
    .o_mac_start  (o_mac_start),
    .i_mac_done   (mac_done),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (out_ready),
    .o_primed     (o_primed),
    .o_busy       (o_busy)
  );

  // MAC responder: done pulses in the cycle right after a start pulse.
  always @(negedge clk) start_neg = o_mac_start;
  always @(posedge clk) begin
    #1;
    auto_done = start_neg;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted sample becomes a script of steps that are consumed in order.
  localparam int K_SHIFT = 0;
  localparam int K_START = 1;
  localparam int K_WAIT  = 2;
  localparam int K_OUT   = 3;

  typedef struct {
    int kind;
    int ph;
  } step_t;

  step_t script[$];
  int    fill_m   = 0;
  bit    model_on = 1'b0;

  task automatic model_accept();
    bit run;
`ifdef PPI_CTRL_PRIME_GATE_EN
    run = !(fill_m < N - 1);
`else
    run = 1'b1;
`endif
    script.push_back('{K_SHIFT, 0});
    if (run) begin
      for (int p = 0; p < L; p++) begin
        script.push_back('{K_START, p});
        script.push_back('{K_WAIT, p});
        script.push_back('{K_OUT, p});
      end
    end
  endtask

  always begin
    @(negedge clk);
    if (model_on) begin
      int k;
      int ph;
      k  = (script.size() == 0) ? -1 : script[0].kind;
      ph = (script.size() == 0) ? 0 : script[0].ph;
      check("m_data_ready", int'(o_data_ready), int'(k == -1));
      check("m_busy", int'(o_busy), int'(k != -1));
      check("m_sr_ena", int'(o_sr_ena), int'(k == K_SHIFT));
      check("m_mac_start", int'(o_mac_start), int'(k == K_START));
      check("m_out_valid", int'(o_out_valid), int'(k == K_OUT));
      check("m_phase", int'(o_phase), ph);
      check("m_primed", int'(o_primed), int'(fill_m == N));
    end
    @(posedge clk);
    if (rst) begin
      script.delete();
      fill_m   = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (script.size() == 0) begin
        if (data_valid) model_accept();
      end else begin
        case (script[0].kind)
          K_SHIFT: begin
            void'(script.pop_front());
            if (fill_m < N) fill_m++;
          end
          K_START: void'(script.pop_front());
          K_WAIT:  if (mac_done) void'(script.pop_front());
          K_OUT:   if (out_ready) void'(script.pop_front());
          default: void'(script.pop_front());
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (o_data_ready) break;
      tick();
    end
    check(name, int'(o_data_ready), 1);
  endtask

  task automatic wait_start(input string name, input int ph);
    for (int i = 0; i < 100; i++) begin
      if (o_mac_start && (int'(o_phase) == ph)) break;
      tick();
    end
    check(name, int'(o_mac_start), 1);
  endtask

  task automatic run_sample();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_idle("run_sample_idle");
  endtask

  int rec_ov[20];
  int rec_ph[20];
  int rec_rdy[20];
  int rec_ms[20];
  int sr_pos[$];
  int ov_cnt;

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_data_ready", int'(o_data_ready), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_phase", int'(o_phase), 0);
    check("rst_primed", int'(o_primed), 0);
    check("rst_sr_ena", int'(o_sr_ena), 0);
    check("rst_out_valid", int'(o_out_valid), 0);
    rst = 1'b0;
    tick();

    // Single sample, zero-wait MAC, always-ready sink
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t1_sr_ena_t1", int'(o_sr_ena), 1);
    for (int k = 1; k <= 16; k++) begin
      rec_ov[k]  = int'(o_out_valid);
      rec_ph[k]  = int'(o_phase);
      rec_rdy[k] = int'(o_data_ready);
      rec_ms[k]  = int'(o_mac_start);
      tick();
    end
    check("t1_mac_start_t2", rec_ms[2], 1);
    check("t1_ov_t4", rec_ov[4], 1);
    check("t1_ph_t4", rec_ph[4], 0);
    check("t1_ov_t7", rec_ov[7], 1);
    check("t1_ph_t7", rec_ph[7], 1);
    check("t1_ov_t10", rec_ov[10], 1);
    check("t1_ph_t10", rec_ph[10], 2);
    check("t1_ov_t13", rec_ov[13], 1);
    check("t1_ph_t13", rec_ph[13], 3);
    check("t1_ready_t13", rec_rdy[13], 0);
    check("t1_ready_t14", rec_rdy[14], 1);
    ov_cnt = 0;
    for (int k = 1; k <= 16; k++) ov_cnt += rec_ov[k];
    check("t1_ov_count", ov_cnt, 4);

    // Backpressure at phase 2
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_out_valid && (o_phase == 2'd2)) break;
      tick();
    end
    check("t2_reach_ph2", int'(o_out_valid), 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_hold_valid", int'(o_out_valid), 1);
      check("t2_hold_phase", int'(o_phase), 2);
      check("t2_no_start", int'(o_mac_start), 0);
    end
    out_ready = 1'b1;
    wait_idle("t2_idle");

    // Continuous data_valid: one shift per full period
    data_valid = 1'b1;
    for (int c = 0; c < 44; c++) begin
      tick();
      if (o_sr_ena) sr_pos.push_back(c);
    end
    data_valid = 1'b0;
    check("t3_sr_count", sr_pos.size(), 4);
    if (sr_pos.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t3_sr_spacing", sr_pos[i] - sr_pos[i-1], 3 * L + 2);
    end
    wait_idle("t3_idle");

    // Delay-line fill from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ov_cnt = 0;
    for (int s = 1; s <= N; s++) begin
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      check("t4_sr_ena", int'(o_sr_ena), 1);
      check("t4_primed_in_shift", int'(o_primed), 0);
      tick();
      check("t4_primed_after", int'(o_primed), int'(s == N));
      for (int i = 0; i < 200; i++) begin
        if (o_data_ready) break;
        if (o_out_valid) ov_cnt++;
        tick();
      end
      check("t4_idle", int'(o_data_ready), 1);
    end
    check("t4_ov_total", ov_cnt, EXP_OV_FILL);

    // Reset while waiting on the MAC at phase 1; a late done is ignored
    auto_mac = 1'b0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_start("t5_start_p0", 0);
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t5_out_p0", int'(o_out_valid), 1);
    tick();
    tick();
    check("t5_wait_busy", int'(o_busy), 1);
    check("t5_wait_phase", int'(o_phase), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_done = 1'b1;
    check("t5_rst_busy", int'(o_busy), 0);
    check("t5_rst_phase", int'(o_phase), 0);
    check("t5_rst_primed", int'(o_primed), 0);
    check("t5_rst_ready", int'(o_data_ready), 1);
    tick();
    man_done = 1'b0;
    check("t5_late_busy", int'(o_busy), 0);
    check("t5_late_valid", int'(o_out_valid), 0);
    tick();
    check("t5_late_start", int'(o_mac_start), 0);

    // Spurious done in idle and while an output is pending
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t6_idle_busy", int'(o_busy), 0);
    check("t6_idle_sr", int'(o_sr_ena), 0);
    auto_mac = 1'b1;
    for (int s = 0; s < N; s++) run_sample();
    auto_mac = 1'b0;
    out_ready = 1'b0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_start("t6_start_p0", 0);
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t6_out_valid", int'(o_out_valid), 1);
    check("t6_out_phase", int'(o_phase), 0);
    check("t6_out_no_start", int'(o_mac_start), 0);
    tick();
    check("t6_out_valid2", int'(o_out_valid), 1);
    auto_mac = 1'b1;
    out_ready = 1'b1;
    wait_idle("t6_idle");
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
